mrc_result_bcd: RTL and testbench

//  Downstream stage of the MRC unit. Captures the 2*WORD_LENGTH-bit MRC Result when MRC asserts ready.

---
 rtl/mrc_pkg.sv | 24 ++
 rtl/mrc_result_bcd_if.sv | 48 ++++
 rtl/bcd_digit_adjust.sv | 21 ++
 rtl/mrc_result_bcd.sv | 182 ++++++++++++++++++
 tb/tb_mrc_result_bcd.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mrc_pkg.sv
// ---------------------------------------------------------------------------
// mrc_pkg
//   Shared definitions for the MRC result-to-BCD stage.
//   - state_e        : FSM state encoding (IDLE / SHIFT / FINISH)
//   - BCD_ERR_DIGIT  : nibble used for every digit of the "Err" display code
//   - min_digits()   : decimal digits needed to show 2^bits-1
// ---------------------------------------------------------------------------
package mrc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam logic [3:0] BCD_ERR_DIGIT = 4'hF;

  // ceil(bits * log10(2)), with log10(2) approximated as 0.30103.
  // Exact for every width of practical interest (gives 10 for 32 bits).
  function automatic int min_digits(input int bits);
    return (bits * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/mrc_result_bcd_if.sv
// ---------------------------------------------------------------------------
// mrc_result_bcd_if
//   Bundle between the MRC unit (master) and the BCD conversion stage (slave).
//
//   Handshake: start is a one-sided request with no ready return. The stage
//   captures Result/error on a rising edge where start=1 while it is idle and
//   not presenting its done pulse; any other start is dropped, never queued.
//   busy=1 tells the requester a start would currently be ignored. done is a
//   single-cycle pulse marking that bcd/sign/err_flag have just updated; those
//   outputs then hold until the next done.
//
//   Signals
//     start     master->slave  capture request (MRC ready)
//     Result    master->slave  2*WORD_LENGTH-bit MRC result
//     error     master->slave  MRC error flag, sampled with start
//     busy      slave->master  conversion in progress
//     done      slave->master  one-cycle update pulse
//     bcd       slave->master  packed BCD, digit 0 in [3:0]
//     sign      slave->master  negative input (signed build only)
//     err_flag  slave->master  last capture carried the MRC error
//     dbg_state slave->master  current FSM state, for observation
// ---------------------------------------------------------------------------
interface mrc_result_bcd_if #(
  parameter int WORD_LENGTH = 16,
  parameter int DIGITS      = 10
);

  logic                       start;
  logic [2*WORD_LENGTH-1:0]   Result;
  logic                       error;
  logic                       busy;
  logic                       done;
  logic [4*DIGITS-1:0]        bcd;
  logic                       sign;
  logic                       err_flag;
  mrc_pkg::state_e            dbg_state;

  modport master (
    output start, Result, error,
    input  busy, done, bcd, sign, err_flag, dbg_state
  );

  modport slave (
    input  start, Result, error,
    output busy, done, bcd, sign, err_flag, dbg_state
  );

endinterface

// File: rtl/bcd_digit_adjust.sv
// ---------------------------------------------------------------------------
// bcd_digit_adjust
//   Double-dabble correction for one BCD digit: a digit of 5 or more gets +3
//   so that the following left shift carries correctly into the next digit.
//   Ports
//     digit_i  in  4  current digit
//     digit_o  out 4  adjusted digit
// ---------------------------------------------------------------------------
module bcd_digit_adjust (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/mrc_result_bcd.sv
// ---------------------------------------------------------------------------
// mrc_result_bcd
//   Downstream stage of the MRC unit. Captures the 2*WORD_LENGTH-bit result on
//   an accepted start and converts it to packed BCD with an iterative
//   double-dabble engine (one bit per clock). An MRC error is passed through as
//   an all-0xF "Err" code with err_flag set.
//
//   Ports
//     clk    in  1   rising-edge clock
//     reset  in  1   synchronous, active-high; aborts a conversion silently
//     bus    slave modport of mrc_result_bcd_if (start/Result/error in,
//            busy/done/bcd/sign/err_flag/dbg_state out)
//
//   Configuration
//     SIGNED_INPUT_EN  defined: Result is two's complement, sign latched from
//                      the MSB and the magnitude converted.
//                      undefined: Result is unsigned, sign stays 0.
//
//   Timing (capture at edge k, W = WORD_LENGTH)
//     clean : shifts on edges k+1..k+2W, done registered at edge k+2W+1
//     error : done registered at edge k+1
//   The cycle in which done is high is still treated as part of the handoff,
//   so a held start restarts one edge later (back-to-back spacing 2W+3).
// ---------------------------------------------------------------------------
module mrc_result_bcd
  import mrc_pkg::*;
#(
  parameter int WORD_LENGTH = 16,
  parameter int DIGITS      = min_digits(2 * WORD_LENGTH)
) (
  input  logic             clk,
  input  logic             reset,
  mrc_result_bcd_if.slave  bus
);

  localparam int RW    = 2 * WORD_LENGTH;
  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + RW;
  localparam int CNT_W = $clog2(RW + 1);

  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(RW - 1);
  localparam logic [RW-1:0]    ONE_RW     = RW'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              sign_q, sign_d;
  logic              err_q, err_d;
  logic              sign_pend_q, sign_pend_d;
  logic              err_pend_q, err_pend_d;

  // Input interpretation
  logic              sign_in;
  logic [RW-1:0]     mag_in;

`ifdef SIGNED_INPUT_EN
  // Negating 0x8000_0000 yields itself, which read as unsigned is 2^31.
  assign sign_in = bus.Result[RW-1];
  assign mag_in  = sign_in ? ((~bus.Result) + ONE_RW) : bus.Result;
`else
  logic [RW-1:0] unused_one;
  assign unused_one = ONE_RW;
  assign sign_in    = 1'b0;
  assign mag_in     = bus.Result;
`endif

  // Parallel "+3 if >=5" on every digit of the BCD field
  logic [BCD_W-1:0]  bcd_field;
  logic [BCD_W-1:0]  bcd_adj;
  logic [SR_W-1:0]   sr_adj;

  assign bcd_field = sr_q[SR_W-1 -: BCD_W];

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (bcd_field[4*i +: 4]),
      .digit_o (bcd_adj[4*i +: 4])
    );
  end

  assign sr_adj = {bcd_adj, sr_q[RW-1:0]};

  // Next-state / datapath
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    bcd_d       = bcd_q;
    sign_d      = sign_q;
    err_d       = err_q;
    sign_pend_d = sign_pend_q;
    err_pend_d  = err_pend_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !done_q) begin
          if (bus.error) begin
            state_d     = ST_FINISH;
            err_pend_d  = 1'b1;
            sign_pend_d = 1'b0;
          end else begin
            state_d     = ST_SHIFT;
            sr_d        = {{BCD_W{1'b0}}, mag_in};
            cnt_d       = '0;
            busy_d      = 1'b1;
            err_pend_d  = 1'b0;
            sign_pend_d = sign_in;
          end
        end
      end

      ST_SHIFT: begin
        // The width rule guarantees the top bit of sr_adj is always 0.
        sr_d  = sr_adj << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_SHIFT) begin
          state_d = ST_FINISH;
          busy_d  = 1'b0;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        if (err_pend_q) begin
          bcd_d  = {DIGITS{BCD_ERR_DIGIT}};
          err_d  = 1'b1;
          sign_d = 1'b0;
        end else begin
          bcd_d  = sr_q[SR_W-1 -: BCD_W];
          err_d  = 1'b0;
          sign_d = sign_pend_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bcd_q       <= '0;
      sign_q      <= 1'b0;
      err_q       <= 1'b0;
      sign_pend_q <= 1'b0;
      err_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bcd_q       <= bcd_d;
      sign_q      <= sign_d;
      err_q       <= err_d;
      sign_pend_q <= sign_pend_d;
      err_pend_q  <= err_pend_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bcd       = bcd_q;
  assign bus.sign      = sign_q;
  assign bus.err_flag  = err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mrc_result_bcd.sv
// ---------------------------------------------------------------------------
// tb_mrc_result_bcd
//   Scoreboard bench for mrc_result_bcd (WORD_LENGTH=16, DIGITS=10).
//   Expected {err_flag, sign, bcd} words come from a decimal reference model
//   (repeated %10 on the magnitude) and are queued when a capture is issued;
//   a negedge monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_mrc_result_bcd;

  localparam int W  = 16;
  localparam int RW = 2 * W;
  localparam int ND = 10;
  localparam int EW = 4 * ND + 2;

  logic clk;
  logic reset;

  mrc_result_bcd_if #(.WORD_LENGTH(W), .DIGITS(ND)) bus ();

  mrc_result_bcd #(.WORD_LENGTH(W), .DIGITS(ND)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  int            n_cmp;
  int            n_fail;
  int            n_done;
  int unsigned   done_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: {err_flag, sign, bcd}
  function automatic logic [EW-1:0] model(input logic [RW-1:0] r, input logic e);
    longint unsigned m;
    logic            s;
    logic [4*ND-1:0] b;
    if (e) begin
      b = '1;
      return {1'b1, 1'b0, b};
    end
`ifdef SIGNED_INPUT_EN
    s = r[RW-1];
    m = s ? (64'd4294967296 - longint'(r)) : longint'(r);
`else
    s = 1'b0;
    m = longint'(r);
`endif
    for (int i = 0; i < ND; i++) begin
      b[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {1'b0, s, b};
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (bus.done) begin
      n_done++;
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        check("result", 64'({bus.err_flag, bus.sign, bus.bcd}), 64'(exp_q.pop_front()));
      end
    end
  end

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one capture, wait for done; lat = edges after capture edge to done.
  task automatic convert(input logic [RW-1:0] r, input logic e,
                         output int lat, output int busy_cnt);
    bus.start  = 1'b1;
    bus.Result = r;
    bus.error  = e;
    tick();
    exp_q.push_back(model(r, e));
    bus.start = 1'b0;
    bus.error = 1'b0;
    busy_cnt  = int'(bus.busy);
    lat       = 0;
    while (!bus.done && lat < 100) begin
      tick();
      lat++;
      if (bus.busy) busy_cnt++;
    end
    tick();
  endtask

  task automatic wait_dones(input int base, input int want);
    int guard;
    guard = 0;
    while ((n_done - base) < want && guard < 200) begin
      tick();
      guard++;
    end
  endtask

  int lat, bc, d0;
  logic [RW-1:0] r;
  logic          e;

  initial begin
    n_cmp = 0; n_fail = 0; n_done = 0; cyc = 0;
    bus.start = 1'b0; bus.Result = '0; bus.error = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_bcd",  64'(bus.bcd), 64'd0);
    check("rst_flags", 64'({bus.sign, bus.err_flag}), 64'd0);

    // 16387^2
    convert(32'd268533769, 1'b0, lat, bc);
    check("t1_latency", 64'(lat), 64'd33);
    check("t1_busy_cycles", 64'(bc), 64'd32);
    check("t1_bcd", 64'(bus.bcd), 64'h0268533769);

    // All ones
    convert(32'hFFFF_FFFF, 1'b0, lat, bc);
`ifdef SIGNED_INPUT_EN
    check("t2_bcd", 64'(bus.bcd), 64'h0000000001);
    check("t2_sign", 64'(bus.sign), 64'd1);
`else
    check("t2_bcd", 64'(bus.bcd), 64'h4294967295);
    check("t2_sign", 64'(bus.sign), 64'd0);
`endif

    // Error pass-through, then a clean zero
    convert(32'd123, 1'b1, lat, bc);
    check("t3_latency", 64'(lat), 64'd1);
    check("t3_bcd", 64'(bus.bcd), 64'hFFFFFFFFFF);
    check("t3_err", 64'(bus.err_flag), 64'd1);
    convert(32'd0, 1'b0, lat, bc);
    check("t3_zero_bcd", 64'(bus.bcd), 64'd0);
    check("t3_zero_err", 64'(bus.err_flag), 64'd0);

    // Start during shift 10 is ignored
    d0 = n_done;
    bus.start = 1'b1; bus.Result = 32'd123456789; bus.error = 1'b0;
    tick();
    exp_q.push_back(model(32'd123456789, 1'b0));
    bus.start = 1'b0;
    repeat (10) tick();
    bus.start = 1'b1; bus.Result = 32'd5;
    tick();
    bus.start = 1'b0;
    wait_dones(d0, 1);
    repeat (40) tick();
    check("t4_done_count", 64'(n_done - d0), 64'd1);

    // Reset mid-conversion
    bus.start = 1'b1; bus.Result = 32'd555555; bus.error = 1'b0;
    tick();
    bus.start = 1'b0;
    repeat (20) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_busy", 64'(bus.busy), 64'd0);
    check("t5_outs", 64'({bus.done, bus.sign, bus.err_flag, bus.bcd}), 64'd0);
    d0 = n_done;
    repeat (40) tick();
    check("t5_no_done", 64'(n_done - d0), 64'd0);
    convert(32'd99, 1'b0, lat, bc);
    check("t5_bcd", 64'(bus.bcd), 64'h0000000099);

    // Held start: two back-to-back conversions
    d0 = n_done;
    done_cyc.delete();
    bus.start = 1'b1; bus.Result = 32'd7; bus.error = 1'b0;
    exp_q.push_back(model(32'd7, 1'b0));
    exp_q.push_back(model(32'd7, 1'b0));
    repeat (40) tick();
    bus.start = 1'b0;
    wait_dones(d0, 2);
    repeat (40) tick();
    check("t6_done_count", 64'(n_done - d0), 64'd2);
    if (done_cyc.size() >= 2) begin
      check("t6_spacing", 64'(done_cyc[1] - done_cyc[0]), 64'd35);
    end else begin
      check("t6_spacing_missing", 64'(done_cyc.size()), 64'd2);
    end
    check("t6_bcd", 64'(bus.bcd), 64'h0000000007);

    // Randomized conversions
    for (int i = 0; i < 24; i++) begin
      r = $urandom();
      if (i == 0) r = 32'h8000_0000;
      if (i == 1) r = 32'h7FFF_FFFF;
      e = ($urandom_range(0, 4) == 0);
      convert(r, e, lat, bc);
      check("rand_latency", 64'(lat), e ? 64'd1 : 64'd33);
    end

    repeat (5) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
